// File: rtl/lmmi_access_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// lmmi_access_ctrl: one-at-a-time command port onto NUM_INST LMMI slaves,
// with a per-phase timeout and a saturating error count.        Rev 1.0
// ------------------------------------------------------------------------
module lmmi_access_ctrl #(
  parameter int NUM_INST    = 2,
  parameter int TIMEOUT_CYC = 255,
  localparam int INST_W     = (NUM_INST > 1) ? $clog2(NUM_INST) : 1,
  localparam int CNT_W      = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [INST_W-1:0]   cmd_inst,
  input  logic [7:0]          cmd_offset,
  input  logic [7:0]          cmd_wdata,
  output logic                rsp_valid,
  output logic [7:0]          rsp_rdata,
  output logic                rsp_err,
  output logic [7:0]          err_cnt,
  output logic [NUM_INST-1:0] lmmi_request,
  output logic                lmmi_wr_rdn,
  output logic [7:0]          lmmi_offset,
  output logic [7:0]          lmmi_wdata,
  input  logic [NUM_INST-1:0] lmmi_ready,
  input  logic [7:0]          lmmi_rdata [NUM_INST],
  input  logic [NUM_INST-1:0] lmmi_rdata_valid
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_RDWAIT = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                wr_q, wr_d;
  logic [7:0]          offset_q, offset_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                bad_q, bad_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_INST-1:0] req_q, req_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [7:0]          rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic                sel_ready;
  logic                sel_valid;
  logic [7:0]          sel_rdata;

  // Only the latched target port is ever looked at; others are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_valid = 1'b0;
    sel_rdata = 8'h00;
    for (int i = 0; i < NUM_INST; i++) begin
      if (int'(inst_q) == i) begin
        sel_ready = lmmi_ready[i];
        sel_valid = lmmi_rdata_valid[i];
        sel_rdata = lmmi_rdata[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    wr_d        = wr_q;
    offset_d    = offset_q;
    wdata_d     = wdata_q;
    bad_d       = bad_q;
    cnt_d       = cnt_q;
    req_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;
    cmd_ready_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          inst_d   = cmd_inst;
          wr_d     = cmd_wr;
          offset_d = cmd_offset;
          wdata_d  = cmd_wdata;
          bad_d    = (int'(cmd_inst) >= NUM_INST);
          cnt_d    = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (bad_q) begin
          // Bad index spends one silent cycle here so every command reports alike.
          state_d     = S_RESP;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 8'h00;
        end else if (sel_ready) begin
          if (wr_q) begin
            state_d     = S_RESP;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = 8'h00;
          end else if (sel_valid) begin
            state_d     = S_RESP;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = sel_rdata;
          end else begin
            cnt_d   = '0;
            state_d = S_RDWAIT;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d     = S_RESP;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 8'h00;
        end
      end
      S_RDWAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (sel_valid) begin
          state_d     = S_RESP;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = sel_rdata;
        end else if (cnt_q == TMO_LAST) begin
          state_d     = S_RESP;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 8'h00;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered outputs are decoded from the next state.
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    if (state_d == S_REQ && !bad_d) begin
      for (int i = 0; i < NUM_INST; i++) begin
        req_d[i] = (int'(inst_d) == i);
      end
    end
    if (state_d == S_RESP && rsp_err_d && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= S_IDLE;
      inst_q      <= '0;
      wr_q        <= 1'b0;
      offset_q    <= 8'h00;
      wdata_q     <= 8'h00;
      bad_q       <= 1'b0;
      cnt_q       <= '0;
      req_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      wr_q        <= wr_d;
      offset_q    <= offset_d;
      wdata_q     <= wdata_d;
      bad_q       <= bad_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign err_cnt      = err_cnt_q;
  assign lmmi_request = req_q;
  assign lmmi_wr_rdn  = wr_q;
  assign lmmi_offset  = offset_q;
  assign lmmi_wdata   = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lmmi_access_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_lmmi_access_ctrl: directed commands against a per-cycle timeline model.
// Rev 1.0
// ------------------------------------------------------------------------
module tb_lmmi_access_ctrl;

  localparam int NI   = 3;
  localparam int TMO  = 8;
  localparam int NCYC = 8192;
  localparam int LAST = NCYC - 1;
  localparam int NEVER = 1000;

  localparam int F_CR = 0, F_REQ = 1, F_RV = 2, F_RD = 3, F_ER = 4,
                 F_EC = 5, F_WR = 6, F_OFF = 7, F_WD = 8;

  logic          clk = 1'b0;
  logic          srst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [1:0]    cmd_inst;
  logic [7:0]    cmd_offset;
  logic [7:0]    cmd_wdata;
  logic          rsp_valid;
  logic [7:0]    rsp_rdata;
  logic          rsp_err;
  logic [7:0]    err_cnt;
  logic [NI-1:0] lmmi_request;
  logic          lmmi_wr_rdn;
  logic [7:0]    lmmi_offset;
  logic [7:0]    lmmi_wdata;
  logic [NI-1:0] lmmi_ready;
  logic [7:0]    lmmi_rdata [NI];
  logic [NI-1:0] lmmi_rdata_valid;

  lmmi_access_ctrl #(.NUM_INST(NI), .TIMEOUT_CYC(TMO)) dut (
    .clk              (clk),
    .srst             (srst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_wr           (cmd_wr),
    .cmd_inst         (cmd_inst),
    .cmd_offset       (cmd_offset),
    .cmd_wdata        (cmd_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_err          (rsp_err),
    .err_cnt          (err_cnt),
    .lmmi_request     (lmmi_request),
    .lmmi_wr_rdn      (lmmi_wr_rdn),
    .lmmi_offset      (lmmi_offset),
    .lmmi_wdata       (lmmi_wdata),
    .lmmi_ready       (lmmi_ready),
    .lmmi_rdata       (lmmi_rdata),
    .lmmi_rdata_valid (lmmi_rdata_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int m_ec    = 0;

  // Expected value of every output in every cycle.
  logic          e_cr  [NCYC];
  logic [NI-1:0] e_req [NCYC];
  logic          e_rv  [NCYC];
  logic [7:0]    e_rd  [NCYC];
  logic          e_er  [NCYC];
  logic [7:0]    e_ec  [NCYC];
  logic          e_wr  [NCYC];
  logic [7:0]    e_off [NCYC];
  logic [7:0]    e_wd  [NCYC];

  // Observations used by the hand-computed literal checks.
  int            mon_req_n;
  logic [NI-1:0] mon_req;
  logic          mon_wr;
  logic [7:0]    mon_off;
  logic [7:0]    mon_wd;
  int            mon_rsp_n;
  int            mon_rsp_cyc;
  logic [7:0]    mon_rd;
  logic          mon_er;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic paint(input int f, input int from, input int to, input int v);
    for (int c = from; c <= to && c < NCYC; c++) begin
      case (f)
        F_CR:    e_cr[c]  = v[0];
        F_REQ:   e_req[c] = v[NI-1:0];
        F_RV:    e_rv[c]  = v[0];
        F_RD:    e_rd[c]  = v[7:0];
        F_ER:    e_er[c]  = v[0];
        F_EC:    e_ec[c]  = v[7:0];
        F_WR:    e_wr[c]  = v[0];
        F_OFF:   e_off[c] = v[7:0];
        default: e_wd[c]  = v[7:0];
      endcase
    end
  endtask

  task automatic paint_reset(input int from);
    paint(F_CR, from, LAST, 1);
    for (int f = F_REQ; f <= F_WD; f++) paint(f, from, LAST, 0);
  endtask

  task automatic mon_clear();
    mon_req_n = 0; mon_req = '0; mon_wr = 1'b0; mon_off = 8'h00; mon_wd = 8'h00;
    mon_rsp_n = 0; mon_rsp_cyc = -1; mon_rd = 8'hXX; mon_er = 1'bx;
  endtask

  task automatic drive_idle();
    srst = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_inst = 2'd0;
    cmd_offset = 8'h00; cmd_wdata = 8'h00;
    lmmi_ready = '0; lmmi_rdata_valid = '0;
    for (int p = 0; p < NI; p++) lmmi_rdata[p] = 8'hE0 + 8'(p);
  endtask

  // d: cycles of request before lmmi_ready; vd: cycles from ready to
  // rdata_valid (0 = same cycle); rst_rel >= 0 pulses srst at ready+rst_rel.
  task automatic do_cmd(input bit wr, input int inst, input logic [7:0] off,
                        input logic [7:0] wd, input int d, input int vd,
                        input logic [7:0] rd, input bit noise, input int rst_rel);
    int a, r, rsp_t, s, req_end, end_t, busy_t;
    bit bad, err, abort;
    logic [7:0] exp_rd;
    a = cyc;
    bad = (inst >= NI);
    r = a + 1 + d;
    err = 1'b0;
    exp_rd = 8'h00;
    req_end = a;
    if (bad) begin
      rsp_t = a + 2; err = 1'b1;
    end else if (d >= TMO) begin
      req_end = a + TMO; rsp_t = a + 1 + TMO; err = 1'b1;
    end else begin
      req_end = r;
      if (wr || vd == 0) begin
        rsp_t = r + 1;
        if (!wr) exp_rd = rd;
      end else if (vd <= TMO) begin
        rsp_t = r + 1 + vd; exp_rd = rd;
      end else begin
        rsp_t = r + 1 + TMO; err = 1'b1;
      end
    end
    s = (rst_rel >= 0) ? r + rst_rel : -1;
    abort = (s >= 0) && (s < rsp_t);

    paint(F_CR, a + 1, rsp_t, 0);
    paint(F_CR, rsp_t + 1, LAST, 1);
    paint(F_WR, a + 1, LAST, int'(wr));
    paint(F_OFF, a + 1, LAST, int'(off));
    paint(F_WD, a + 1, LAST, int'(wd));
    paint(F_REQ, a + 1, req_end, bad ? 0 : (1 << inst));
    paint(F_REQ, req_end + 1, LAST, 0);
    paint(F_RV, rsp_t, rsp_t, 1);
    paint(F_RV, rsp_t + 1, LAST, 0);
    paint(F_RD, rsp_t, LAST, int'(exp_rd));
    paint(F_ER, rsp_t, LAST, int'(err));
    if (err && !abort) begin
      if (m_ec < 255) m_ec++;
      paint(F_EC, rsp_t, LAST, m_ec);
    end
    if (abort) begin
      paint_reset(s + 1);
      m_ec = 0;
    end
    end_t  = abort ? s + 1 : rsp_t;
    busy_t = abort ? s : rsp_t;

    for (int t = a; t <= end_t; t++) begin
      drive_idle();
      if (t == a) begin
        cmd_valid = 1'b1; cmd_wr = wr; cmd_inst = 2'(inst);
        cmd_offset = off; cmd_wdata = wd;
      end else if (noise && t <= busy_t) begin
        cmd_valid = 1'b1; cmd_wr = ~wr; cmd_inst = 2'((inst + 1) % 4);
        cmd_offset = ~off; cmd_wdata = ~wd;
      end
      srst = abort && (t == s);
      if (noise && t > a) begin
        for (int p = 0; p < NI; p++) begin
          if (p != inst) begin
            lmmi_ready[p] = 1'b1; lmmi_rdata_valid[p] = 1'b1;
          end
        end
      end
      if (!bad && t > a && t >= r) lmmi_ready[inst] = 1'b1;
      if (!bad && t == r + vd) begin
        lmmi_rdata_valid[inst] = 1'b1;
        lmmi_rdata[inst] = rd;
      end
      @(posedge clk);
      #1;
    end
    drive_idle();
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < NCYC) begin
      check("cmd_ready",    32'(cmd_ready),    32'(e_cr[cyc]));
      check("lmmi_request", 32'(lmmi_request), 32'(e_req[cyc]));
      check("rsp_valid",    32'(rsp_valid),    32'(e_rv[cyc]));
      check("rsp_rdata",    32'(rsp_rdata),    32'(e_rd[cyc]));
      check("rsp_err",      32'(rsp_err),      32'(e_er[cyc]));
      check("err_cnt",      32'(err_cnt),      32'(e_ec[cyc]));
      check("lmmi_wr_rdn",  32'(lmmi_wr_rdn),  32'(e_wr[cyc]));
      check("lmmi_offset",  32'(lmmi_offset),  32'(e_off[cyc]));
      check("lmmi_wdata",   32'(lmmi_wdata),   32'(e_wd[cyc]));
    end
    if (|lmmi_request) begin
      mon_req_n++;
      mon_req = lmmi_request; mon_wr = lmmi_wr_rdn;
      mon_off = lmmi_offset;  mon_wd = lmmi_wdata;
    end
    if (rsp_valid) begin
      mon_rsp_n++;
      mon_rsp_cyc = cyc; mon_rd = rsp_rdata; mon_er = rsp_err;
    end
  end

  typedef struct {
    bit         wr;
    int         inst;
    logic [7:0] off;
    logic [7:0] wd;
    int         d;
    int         vd;
    logic [7:0] rd;
    bit         noise;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #(NCYC * 10 + 1000);
    $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int a0;
    drive_idle();
    srst = 1'b1;
    mon_clear();
    paint_reset(0);
    tbl[0] = '{1'b0, 1, 8'h01, 8'h00, 0,     0,     8'hC3, 1'b1};
    tbl[1] = '{1'b1, 0, 8'h02, 8'h11, 7,     0,     8'h00, 1'b0};
    tbl[2] = '{1'b1, 2, 8'h03, 8'h22, 8,     0,     8'h00, 1'b1};
    tbl[3] = '{1'b0, 2, 8'h04, 8'h00, 0,     8,     8'h5A, 1'b1};
    tbl[4] = '{1'b0, 0, 8'h05, 8'h00, 0,     9,     8'h6B, 1'b0};
    tbl[5] = '{1'b0, 1, 8'h06, 8'h00, 7,     0,     8'h81, 1'b0};
    tbl[6] = '{1'b1, 0, 8'hFF, 8'hFE, 2,     0,     8'h00, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    srst = 1'b0;
    chk_en = 1'b1;
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_err_cnt", 32'(err_cnt), 32'd0);

    // Write to port 1 with ready held high.
    mon_clear(); a0 = cyc;
    do_cmd(1'b1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 1'b0, -1);
    check("wr_req_cycles", 32'(mon_req_n), 32'd1);
    check("wr_req_vector", 32'(mon_req), 32'b010);
    check("wr_wr_rdn", 32'(mon_wr), 32'd1);
    check("wr_offset", 32'(mon_off), 32'h10);
    check("wr_wdata", 32'(mon_wd), 32'hA5);
    check("wr_latency", 32'(mon_rsp_cyc - a0), 32'd2);
    check("wr_err", 32'(mon_er), 32'd0);

    // Read from port 0: ready after 3 cycles, data 4 cycles later, strays elsewhere.
    mon_clear(); a0 = cyc;
    do_cmd(1'b0, 0, 8'h22, 8'h00, 3, 4, 8'h3C, 1'b1, -1);
    check("rd_req_cycles", 32'(mon_req_n), 32'd4);
    check("rd_rdata", 32'(mon_rd), 32'h3C);
    check("rd_err", 32'(mon_er), 32'd0);
    check("rd_latency", 32'(mon_rsp_cyc - a0), 32'd9);

    // Request timeout with ready never asserted.
    mon_clear(); a0 = cyc;
    do_cmd(1'b0, 2, 8'h30, 8'h00, NEVER, NEVER, 8'h00, 1'b0, -1);
    check("tmo_req_cycles", 32'(mon_req_n), 32'd8);
    check("tmo_err", 32'(mon_er), 32'd1);
    check("tmo_rdata", 32'(mon_rd), 32'h00);
    check("tmo_err_cnt", 32'(err_cnt), 32'd1);
    check("tmo_latency", 32'(mon_rsp_cyc - a0), 32'd9);

    // Out-of-range instance.
    mon_clear(); a0 = cyc;
    do_cmd(1'b1, 3, 8'h40, 8'h55, 0, 0, 8'h00, 1'b0, -1);
    check("bad_req_cycles", 32'(mon_req_n), 32'd0);
    check("bad_latency", 32'(mon_rsp_cyc - a0), 32'd2);
    check("bad_err", 32'(mon_er), 32'd1);
    check("bad_err_cnt", 32'(err_cnt), 32'd2);

    // Reset two cycles into the read wait, late data one cycle after.
    mon_clear();
    do_cmd(1'b0, 1, 8'h50, 8'h00, 1, 3, 8'h77, 1'b0, 2);
    check("rst_no_rsp", 32'(mon_rsp_n), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_request", 32'(lmmi_request), 32'd0);
    check("rst_offset", 32'(lmmi_offset), 32'd0);
    mon_clear(); a0 = cyc;
    do_cmd(1'b1, 2, 8'h60, 8'h99, 2, 0, 8'h00, 1'b0, -1);
    check("post_rst_latency", 32'(mon_rsp_cyc - a0), 32'd4);
    check("post_rst_req_vector", 32'(mon_req), 32'b100);
    check("post_rst_err", 32'(mon_er), 32'd0);

    // Boundary cases around the timeout and same-cycle read data.
    foreach (tbl[i]) begin
      do_cmd(tbl[i].wr, tbl[i].inst, tbl[i].off, tbl[i].wd,
             tbl[i].d, tbl[i].vd, tbl[i].rd, tbl[i].noise, -1);
    end

    // Enough consecutive timeouts to saturate the error counter.
    for (int i = 0; i < 300; i++) begin
      do_cmd(1'b1, i % NI, 8'(i), 8'(~i), NEVER, NEVER, 8'h00, 1'b0, -1);
    end
    check("err_cnt_saturated", 32'(err_cnt), 32'd255);

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lmmi_access_ctrl.md
LMMI_ACCESS_CTRL -- requirements
Module: lmmi_access_ctrl

Interface
REQ-001 SHALL have parameter NUM_INST, default 2: number of MIPI bridge LMMI ports served.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255: clk cycles allowed per LMMI phase; legal range 1..65535.
REQ-003 SHALL derive INST_W = max(1, clog2(NUM_INST)) and CNT_W = clog2(TIMEOUT_CYC+1).
REQ-004 Port list, with direction, width and meaning; one clock, reset is synchronous and active-high:
- clk  in  1  60 MHz control clock; all logic on its rising edge.
- srst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_inst  in  INST_W  target bridge index.
- cmd_offset  in  8  LMMI register offset.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  single-cycle completion pulse.
- rsp_rdata  out  8  read data; 0 for writes and errors.
- rsp_err  out  1  timeout or bad index.
- err_cnt  out  8  saturating error count.
- lmmi_request  out  NUM_INST  one-hot request.
- lmmi_wr_rdn  out  1  1 = write.
- lmmi_offset  out  8  shared offset.
- lmmi_wdata  out  8  shared write data.
- lmmi_ready  in  NUM_INST  per-port accept.
- lmmi_rdata  in  8 x NUM_INST  per-port read data (unpacked array).
- lmmi_rdata_valid  in  NUM_INST  per-port read-data strobe.

Function
REQ-005 SHALL implement FSM states IDLE, REQ, RDWAIT, RESP; all outputs driven from flops.
REQ-006 IDLE: cmd_ready=1. When cmd_valid is high, SHALL latch cmd_wr/inst/offset/wdata, clear the counter and move to REQ, or to RESP with error if cmd_inst >= NUM_INST.
REQ-007 cmd_ready SHALL be 0 in every state other than IDLE; exactly one command in flight.
REQ-008 REQ: lmmi_request[inst]=1, all other bits 0; lmmi_wr_rdn/offset/wdata hold latched values and stay stable until exit.
REQ-009 lmmi_request SHALL first assert the cycle after acceptance (1-cycle latency).
REQ-010 In REQ, lmmi_ready[inst]=1 is acceptance. SHALL drop lmmi_request on the next edge, then:
- write -> RESP, err 0.
- read with lmmi_rdata_valid[inst] in the same cycle -> capture lmmi_rdata[inst], go to RESP.
- read otherwise -> clear the counter, go to RDWAIT.
REQ-011 RDWAIT: lmmi_rdata_valid[inst]=1 SHALL capture lmmi_rdata[inst] into rsp_rdata and go to RESP, err 0.
REQ-012 lmmi_ready and lmmi_rdata_valid from non-selected ports, and any valid seen in IDLE or RESP, SHALL be ignored.
REQ-013 Counter SHALL increment each cycle in REQ and RDWAIT. When it reaches TIMEOUT_CYC-1 with no completing event that cycle, SHALL go to RESP with err=1 and rsp_rdata=0, and drop the request.
REQ-014 If a completing event and the timeout fall in the same cycle, the completing event SHALL win.
REQ-015 RESP: rsp_valid=1 for exactly one cycle with rsp_rdata/rsp_err, then IDLE. No backpressure on the response.
REQ-016 Best-case latency, acceptance edge to rsp_valid: write 2 cycles; read 2 cycles with same-cycle data, otherwise 2 + RDWAIT cycles.
REQ-017 err_cnt SHALL increment on each RESP with err=1 and saturate at 255.
REQ-018 rsp_rdata and rsp_err SHALL hold their value outside RESP; only rsp_valid qualifies them.

Reset
REQ-019 srst=1 SHALL force on the next edge: IDLE, cmd_ready=1, lmmi_request=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, err_cnt=0, counter=0, lmmi_wr_rdn=0, lmmi_offset=0, lmmi_wdata=0.
REQ-020 srst during REQ/RDWAIT/RESP SHALL abort the command without rsp_valid. A late lmmi_rdata_valid after reset SHALL be ignored.
REQ-021 srst SHALL take priority over cmd_valid and all LMMI inputs in the same cycle.

Verification
REQ-022 Write: inst 1, offset 0x10, data 0xA5, lmmi_ready[1] held high -> lmmi_request=2'b10 for 1 cycle with wr_rdn=1, offset 0x10, wdata 0xA5; rsp_valid 2 cycles after acceptance, err 0.
REQ-023 Read: inst 0, ready after 3 cycles, rdata_valid[0] 4 cycles later with 0x3C, plus a stray rdata_valid[1] during RDWAIT -> rsp_rdata=0x3C, err 0, stray ignored.
REQ-024 Timeout: TIMEOUT_CYC=8, lmmi_ready tied low -> request high exactly 8 cycles, then rsp_valid with err=1, rsp_rdata=0, err_cnt increments by 1.
REQ-025 Bad index: NUM_INST=3, cmd_inst=3 -> no lmmi_request; rsp_valid with err=1 2 cycles after acceptance.
REQ-026 srst asserted 2 cycles into RDWAIT, with rdata_valid arriving 1 cycle after reset -> no rsp_valid, all outputs at reset values, next command served normally.
REQ-027 300 consecutive timeouts -> err_cnt saturates at 255.
